// File: rtl/cic_comp_pkg.sv
// Shared constants for the CIC compensation FIR: default widths, coefficients, FSM states.
package cic_comp_pkg;

    localparam int NTAPS_DEF  = 16;
    localparam int DECIM_DEF  = 2;
    localparam int IN_W_DEF   = 31;
    localparam int COEF_W_DEF = 18;
    localparam int OUT_W_DEF  = 24;
    localparam int SHIFT_DEF  = 17;

    // Symmetric Q1.17 inverse-sinc^5 response; the taps sum to unity DC gain.
    localparam logic signed [COEF_W_DEF-1:0] COEFS [NTAPS_DEF] = '{
        -18'sd311,   -18'sd1203,  18'sd1587,   18'sd3469,
        -18'sd2919,  -18'sd9671,  18'sd5023,   18'sd69561,
         18'sd69561,  18'sd5023, -18'sd9671,  -18'sd2919,
         18'sd3469,   18'sd1587, -18'sd1203,  -18'sd311
    };

    function automatic int coef_sum();
        int s = 0;
        for (int k = 0; k < NTAPS_DEF; k++) s += int'(COEFS[k]);
        return s;
    endfunction

    localparam int COEF_SUM = coef_sum();

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cic_comp_mac.sv
// Registered multiplier, accumulator and round/shift/saturate stage of the compensation FIR.
// Define CIC_COMP_ROUND_EN to round half up before the shift; otherwise the shift truncates.
module cic_comp_mac
    import cic_comp_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int SHIFT  = SHIFT_DEF,
    parameter int ACC_W  = IN_W_DEF + COEF_W_DEF + 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    input  logic                     last,
    input  logic signed [IN_W-1:0]   sample,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [OUT_W-1:0]  result
);

    localparam int PROD_W = IN_W + COEF_W;

    logic signed [PROD_W-1:0] prod;
    logic                     prod_vld;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_rnd;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [OUT_W-1:0]  sat;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
            result   <= '0;
        end else begin
            prod_vld <= en;
            if (en)
                prod <= PROD_W'(sample) * PROD_W'(coef);
            if (clear)
                acc <= '0;
            else if (prod_vld)
                acc <= acc + ACC_W'(prod);
            if (last)
                result <= sat;
        end
    end

`ifdef CIC_COMP_ROUND_EN
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (SHIFT - 1);
    assign acc_rnd = acc + HALF;
`else
    assign acc_rnd = acc;
`endif

    assign shifted = acc_rnd >>> SHIFT;

    // NOTE: sat gets a value on every path so this block cannot infer a latch.
    always_comb begin
        sat = shifted[OUT_W-1:0];
        if (!((&shifted[ACC_W-1:OUT_W-1]) || !(|shifted[ACC_W-1:OUT_W-1]))) begin
            if (shifted[ACC_W-1])
                sat = {1'b1, {(OUT_W-1){1'b0}}};
            else
                sat = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/cic_comp_fir.sv
// Decimating CIC droop-compensation FIR with one time-multiplexed MAC over a circular buffer.
// Optional CIC_COMP_ROUND_EN selects round-half-up instead of truncation (see cic_comp_mac).
module cic_comp_fir
    import cic_comp_pkg::*;
#(
    parameter int NTAPS  = NTAPS_DEF,
    parameter int DECIM  = DECIM_DEF,
    parameter int IN_W   = IN_W_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int SHIFT  = SHIFT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_clk,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int PW    = $clog2(NTAPS);
    localparam int PHW   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int ACC_W = IN_W + COEF_W + PW;

    state_t                  state;
    logic                    in_clk_q;
    logic                    rise;
    logic                    accept;
    logic                    start;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           tap;
    logic [PW-1:0]           rd_idx;
    logic [PHW-1:0]          phase;
    logic                    flush_cnt;
    logic signed [IN_W-1:0]  sample_buf [NTAPS];
    logic signed [COEF_W-1:0] coef;

    assign busy      = (state == MAC) || (state == FLUSH);
    assign out_valid = (state == DONE);
    assign rise      = in_clk && !in_clk_q;
    assign accept    = rise && !busy;
    assign start     = accept && (phase == PHW'(DECIM - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            in_clk_q <= 1'b0;
            wr_ptr   <= '0;
            phase    <= '0;
            overrun  <= 1'b0;
        end else begin
            in_clk_q <= in_clk;
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
                phase  <= (phase == PHW'(DECIM - 1)) ? '0 : phase + PHW'(1);
            end
            if (rise && busy)
                overrun <= 1'b1;
        end
    end

    // NOTE: the sample buffer is reset entry by entry because the filter must read zeros before it fills.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) sample_buf[i] <= '0;
        end else if (accept) begin
            sample_buf[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tap       <= '0;
            flush_cnt <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state     <= start ? MAC : IDLE;
                    tap       <= '0;
                    flush_cnt <= 1'b0;
                end
                MAC: begin
                    tap <= tap + PW'(1);
                    if (tap == PW'(NTAPS - 1))
                        state <= FLUSH;
                end
                FLUSH: begin
                    flush_cnt <= 1'b1;
                    if (flush_cnt)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Newest sample sits just behind wr_ptr, so tap k reads k entries further back.
    assign rd_idx = wr_ptr - PW'(1) - tap;
    assign coef   = COEF_W'(COEFS[tap]);

    cic_comp_mac #(
        .IN_W   (IN_W),
        .COEF_W (COEF_W),
        .OUT_W  (OUT_W),
        .SHIFT  (SHIFT),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clear  (start),
        .en     (state == MAC),
        .last   ((state == FLUSH) && flush_cnt),
        .sample (sample_buf[rd_idx]),
        .coef   (coef),
        .result (out_data)
    );

endmodule

// File: tb/tb_cic_comp_fir.sv
// Self-checking bench for cic_comp_fir: vector table of filtered streams plus reset/overrun/abort sequences.
module tb_cic_comp_fir;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [30:0] in_data = '0;
    logic               in_clk = 1'b0;
    logic signed [23:0] out_data;
    logic               out_valid;
    logic               busy;
    logic               overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct { int cyc; int data; } ev_t;
    ev_t out_q[$];

    typedef struct {
        string name;
        int    x_first;
        int    x_rest;
        int    nsamp;
        int    period;
        int    idx;
        int    expv;
    } vec_t;

    localparam int LAT = 19;  // NTAPS + 3

`ifdef CIC_COMP_ROUND_EN
    localparam int RND_EXP = -601;  // (-1203 + 1) >> 1
`else
    localparam int RND_EXP = -602;  // -1203 >> 1, floor
`endif

    logic signed [30:0] stim   [64];
    int                 acc_at [64];
    vec_t               vecs   [14];

    cic_comp_fir dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_clk    (in_clk),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            ev_t e;
            e.cyc  = cyc;
            e.data = int'(out_data);
            out_q.push_back(e);
        end
    end

    task automatic check(input string name, input int act, input int exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        in_clk  = 1'b0;
        in_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        out_q.delete();
    endtask

    // One sample per period clk cycles, in_clk high for the first half.
    task automatic run_stream(input int first, input int n, input int period);
        for (int i = first; i < first + n; i++) begin
            @(posedge clk);
            #1;
            in_clk    = 1'b1;
            in_data   = stim[i];
            acc_at[i] = cyc;
            repeat (period / 2) @(posedge clk);
            #1 in_clk = 1'b0;
            repeat (period / 2 - 1) @(posedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;

        // Expected values are the odd taps of the symmetric table, hand-copied.
        vecs[0]  = '{"imp_c1",  131072, 0, 18, 64, 0,  -1203};
        vecs[1]  = '{"imp_c3",  131072, 0, 18, 64, 1,   3469};
        vecs[2]  = '{"imp_c5",  131072, 0, 18, 64, 2,  -9671};
        vecs[3]  = '{"imp_c7",  131072, 0, 18, 64, 3,  69561};
        vecs[4]  = '{"imp_c9",  131072, 0, 18, 64, 4,   5023};
        vecs[5]  = '{"imp_c11", 131072, 0, 18, 64, 5,  -2919};
        vecs[6]  = '{"imp_c13", 131072, 0, 18, 64, 6,   1587};
        vecs[7]  = '{"imp_c15", 131072, 0, 18, 64, 7,   -311};
        vecs[8]  = '{"imp_tail",131072, 0, 18, 64, 8,      0};
        vecs[9]  = '{"neg_imp", -131072, 0, 2, 64, 0,   1203};
        vecs[10] = '{"dc_gain", 131072, 131072, 20, 32, 9, 131072};
        vecs[11] = '{"sat_pos", 1073741823, 1073741823, 20, 32, 9, 8388607};
        vecs[12] = '{"sat_neg", -1073741824, -1073741824, 20, 32, 9, -8388608};
        vecs[13] = '{"round",   65536, 0, 2, 64, 0, RND_EXP};

        // Reset held with in_clk toggling: nothing may move.
        rst = 1'b1;
        in_data = 31'sd12345;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 in_clk = ~in_clk;
            @(negedge clk);
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_busy",      int'(busy),      0);
            check("rst_overrun",   int'(overrun),   0);
            check("rst_out_data",  int'(out_data),  0);
        end
        @(posedge clk);
        #1;
        in_clk  = 1'b0;
        in_data = '0;
        rst     = 1'b0;
        out_q.delete();

        // First sample after release lands at phase 0: buffered, no pass.
        stim[0] = 31'sd131072;
        run_stream(0, 1, 64);
        #1;
        check("first_no_valid", out_q.size(), 0);
        check("first_no_busy",  int'(busy),   0);

        // Second sample starts a pass; probe busy window and output cycle.
        @(posedge clk);
        #1;
        in_clk  = 1'b1;
        in_data = '0;
        a = cyc;
        @(negedge clk);
        check("busy_at_A", int'(busy), 0);
        @(posedge clk);
        #1 in_clk = 1'b0;
        @(negedge clk);
        check("busy_at_A1", int'(busy), 1);
        repeat (17) @(posedge clk);
        @(negedge clk);
        check("busy_at_A18",  int'(busy),      1);
        check("valid_at_A18", int'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        check("busy_at_A19",  int'(busy),      0);
        check("valid_at_A19", int'(out_valid), 1);
        check("data_at_A19",  int'(out_data),  -1203);
        check("lat_cycle",    cyc - a,         LAT);
        @(posedge clk);
        @(negedge clk);
        check("valid_pulse_one", int'(out_valid), 0);
        check("data_holds",      int'(out_data),  -1203);

        // Table of filtered streams.
        for (int v = 0; v < 14; v++) begin
            do_reset();
            for (int i = 0; i < vecs[v].nsamp; i++)
                stim[i] = (i == 0) ? 31'(vecs[v].x_first) : 31'(vecs[v].x_rest);
            run_stream(0, vecs[v].nsamp, vecs[v].period);
            repeat (30) @(posedge clk);
            #1;
            check({vecs[v].name, "_count"}, out_q.size(), vecs[v].nsamp / 2);
            if (out_q.size() > vecs[v].idx) begin
                check({vecs[v].name, "_data"}, out_q[vecs[v].idx].data, vecs[v].expv);
                check({vecs[v].name, "_lat"},
                      out_q[vecs[v].idx].cyc - acc_at[2 * vecs[v].idx + 1], LAT);
            end
            check({vecs[v].name, "_overrun"}, int'(overrun), 0);
        end

        // Overrun: period 8; samples landing in a pass carry 2^20 and must be dropped.
        do_reset();
        for (int i = 0; i < 24; i++)
            stim[i] = (i == 0) ? 31'sd131072 : ((i % 4) >= 2 ? 31'sd1048576 : 31'sd0);
        run_stream(0, 2, 8);
        #1;
        check("ovr_before_drop", int'(overrun), 0);
        run_stream(2, 22, 8);
        repeat (30) @(posedge clk);
        #1;
        check("ovr_sticky", int'(overrun), 1);
        check("ovr_count",  out_q.size(),  6);
        if (out_q.size() == 6) begin
            check("ovr_y0", out_q[0].data, -1203);
            check("ovr_y1", out_q[1].data,  3469);
            check("ovr_y2", out_q[2].data, -9671);
            check("ovr_y3", out_q[3].data, 69561);
            check("ovr_y4", out_q[4].data,  5023);
            check("ovr_y5", out_q[5].data, -2919);
            check("ovr_lat", out_q[0].cyc - acc_at[1], LAT);
        end

        // Reset in the middle of a MAC pass: no output, overrun cleared.
        out_q.delete();
        @(posedge clk);
        #1 in_clk = 1'b1;
        in_data = 31'sd131072;
        repeat (4) @(posedge clk);
        #1 in_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1 in_clk = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("abort_busy_pre", int'(busy), 1);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        in_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_valid", out_q.size(),  0);
        check("abort_overrun",  int'(overrun), 0);
        check("abort_busy",     int'(busy),    0);
        check("abort_out_data", int'(out_data), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cic_comp_fir.md
# cic_comp_fir

Decimate-by-DECIM compensation FIR that consumes the CIC decimator's 31-bit output and strobe. It corrects the CIC's sinc^5 passband droop and halves the rate again, producing saturated OUT_W-bit samples. It uses one time-multiplexed multiplier: a single MAC pass per output over an NTAPS-deep circular sample buffer.

## Interface
- NTAPS, 16: filter length, power of two, ≥4.
- DECIM, 2: output decimation factor, ≥1.
- IN_W, 31: input sample width, signed.
- COEF_W, 18: coefficient width, signed Q1.17.
- OUT_W, 24: output width, signed.
- SHIFT, 17: arithmetic right shift applied to the accumulator, ≥1.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  IN_W  CIC output sample.
- in_clk  in  1  CIC sample clock (level, ~50% duty, clk-synchronous); a new sample is valid on its rising edge.
- out_data  out  OUT_W  filtered sample; holds between updates.
- out_valid  out  1  one-cycle pulse when out_data updates.
- busy  out  1  high while a MAC pass is in progress.
- overrun  out  1  sticky; set when an input sample is dropped.

## Operation
- Accept cycle: the first cycle in which in_clk=1 and the registered in_clk_q=0. In_data is captured in that cycle.
- An accepted sample is written to buf[wr_ptr], and wr_ptr increments mod NTAPS. phase increments mod DECIM.
- When the accepted sample has phase==DECIM-1, the FSM leaves IDLE. For the newest sample n it computes y = Σ_{k=0}^{NTAPS-1} COEFS[k]·x[n-k], reading buf[(wr_ptr_new-1-k) mod NTAPS].
- FSM states and transitions:
  - IDLE → MAC on a starting accept.
  - MAC issues one tap per cycle for NTAPS cycles, then → FLUSH.
  - FLUSH is 2 cycles (product register and final accumulate), then → DONE.
  - DONE drives out_valid and returns to IDLE.
- Arithmetic:
  - Product width is IN_W+COEF_W.
  - Accumulator width is IN_W+COEF_W+log2(NTAPS). It cannot overflow.
  - Result = acc >>> SHIFT, saturated to [−2^(OUT_W-1), 2^(OUT_W-1)−1].
- Overrun: a sample whose accept cycle falls while busy=1 is dropped. It is not written, phase is not advanced, and overrun is set.
- A sample whose accept cycle coincides with the DONE cycle is accepted normally (busy=0 in DONE).
- Initial state after reset: the buffer reads as zero, phase=0, wr_ptr=0.

## Timing
- Reset values: out_data=0, out_valid=0, busy=0, overrun=0, FSM=IDLE, all buffer entries 0, in_clk_q=0.
- Reset asserted mid-pass aborts the pass. No out_valid is produced for it.
- busy=1 from accept cycle A+1 through A+NTAPS+2.
- out_valid=1 exactly at cycle A+NTAPS+3; out_data is valid from the same cycle.
- Throughput requirement: the upstream CIC decimation_ratio must be ≥ NTAPS+4 clk cycles. Otherwise overrun fires.

## Configuration
- CIC_COMP_ROUND_EN defined: add 2^(SHIFT-1) to the accumulator before the shift and saturation (round half up).
- CIC_COMP_ROUND_EN undefined: plain truncation (floor) by the arithmetic shift.

## Structure
- Package cic_comp_pkg holds:
  - the COEFS array constant (NTAPS entries, COEF_W bits) and its sum COEF_SUM;
  - the default widths;
  - the FSM state enum (IDLE, MAC, FLUSH, DONE).
- Sub-module cic_comp_mac holds the registered multiplier, accumulator, round/shift and saturation. It is controlled by clear/enable/last from the FSM in cic_comp_fir.

## Test plan
- Reset:
  - Stimulus: hold rst for 3 cycles with in_clk toggling.
  - Required: all outputs 0 and no out_valid.
  - Stimulus: first in_clk rising edge after release.
  - Required: buffer entry 0 written, no out_valid (phase 0).
- Impulse:
  - Stimulus: x=2^17 at sample 0, then zeros, with in_clk period 64.
  - Required: out_data sequence COEFS[1], COEFS[3], …, COEFS[15], then 0. Each out_valid lands NTAPS+3 cycles after its accept.
- DC:
  - Stimulus: constant x=2^17 for ≥NTAPS samples.
  - Required: steady out_data = COEF_SUM.
- Saturation:
  - Stimulus: constant x=2^30−1.
  - Required: out_data=2^23−1.
  - Stimulus: constant x=−2^30.
  - Required: out_data=−2^23.
- Overrun and reset abort:
  - Stimulus: in_clk period 8.
  - Required: overrun=1 after the first starting accept, and the dropped samples never enter the buffer.
  - Stimulus: rst mid-MAC.
  - Required: no out_valid, overrun cleared.
- Rounding:
  - Stimulus: impulse x=2^16 with odd COEFS[1].
  - Required: first output (COEFS[1]+1)>>1 with CIC_COMP_ROUND_EN, COEFS[1]>>1 without.
